pc_redirect_unit: RTL and testbench

- Parametrised fetch-PC generator and successor to the combinational jump-target calculator.
- Owns the registered fetch PC; computes J/JAL (ID), JR (ID) and taken-branch (EX) targets.
- Arbitrates between the redirect sources and buffers a redirect that arrives while fetch is stalled.
- Sits between the IF stage and the ID/EX redirect sources; drives the IF PC and the flush request.

---
 rtl/pc_redirect_unit_pkg.sv | 17 +
 rtl/pc_redirect_unit_target_calc.sv | 25 ++
 rtl/pc_redirect_unit.sv | 137 +++++++++++++
 tb/tb_pc_redirect_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pc_redirect_unit_pkg.sv
// pc_pkg: redirect source encodings, redirect FSM states and a saturating counter helper.
package pc_pkg;
    localparam logic [1:0] SRC_SEQ = 2'b00;
    localparam logic [1:0] SRC_J   = 2'b01;
    localparam logic [1:0] SRC_JR  = 2'b10;
    localparam logic [1:0] SRC_BR  = 2'b11;

    typedef enum logic [1:0] {
        S_RUN    = 2'b00,
        S_HOLD   = 2'b01,
        S_HOLD_P = 2'b10
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/pc_redirect_unit_target_calc.sv
// target_calc: combinational J, JR and BR target computation plus JR misalignment flag.
module target_calc #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 26,
    parameter int OFF_W = 16,
    parameter int ALIGN = 2
) (
    input  logic [XLEN-1:0]  j_pcp4,
    input  logic [IDX_W-1:0] j_index,
    input  logic [XLEN-1:0]  jr_addr,
    input  logic [XLEN-1:0]  br_pcp4,
    input  logic [OFF_W-1:0] br_off,
    output logic [XLEN-1:0]  j_tgt,
    output logic [XLEN-1:0]  jr_tgt,
    output logic             jr_mis,
    output logic [XLEN-1:0]  br_tgt
);
    logic [XLEN-1:0] off_sext;

    assign off_sext = {{(XLEN-OFF_W){br_off[OFF_W-1]}}, br_off};
    assign j_tgt    = {j_pcp4[XLEN-1:IDX_W+ALIGN], j_index, {ALIGN{1'b0}}};
    assign jr_tgt   = {jr_addr[XLEN-1:ALIGN], {ALIGN{1'b0}}};
    assign jr_mis   = |jr_addr[ALIGN-1:0];
    assign br_tgt   = br_pcp4 + (off_sext << ALIGN);
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with J/JR/BR redirect arbitration and stall-time redirect buffering.
// Optional per-source applied-redirect counters when REDIRECT_STATS_EN is defined.
module pc_redirect_unit
    import pc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              IDX_W    = 26,
    parameter int              OFF_W    = 16,
    parameter int              ALIGN    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             j_valid_i,
    input  logic [XLEN-1:0]  j_pcp4_i,
    input  logic [IDX_W-1:0] j_index_i,
    input  logic             jr_valid_i,
    input  logic [XLEN-1:0]  jr_addr_i,
    input  logic             br_taken_i,
    input  logic [XLEN-1:0]  br_pcp4_i,
    input  logic [OFF_W-1:0] br_off_i,
    output logic [XLEN-1:0]  pc_o,
    output logic             redirect_o,
    output logic [1:0]       redirect_src_o,
    output logic             flush_o,
    output logic             misalign_o,
`ifdef REDIRECT_STATS_EN
    output logic [15:0]      j_cnt_o,
    output logic [15:0]      jr_cnt_o,
    output logic [15:0]      br_cnt_o,
`endif
    output logic             pend_o
);
    if (IDX_W + ALIGN >= XLEN || OFF_W + ALIGN > XLEN) begin : g_param_chk
        $error("pc_redirect_unit: field widths do not fit XLEN");
    end

    localparam logic [XLEN-1:0] STEP = {{(XLEN-1){1'b0}}, 1'b1} << ALIGN;

    state_t          state, state_n;
    logic [XLEN-1:0] j_tgt, jr_tgt, br_tgt, new_tgt, pend_tgt, pend_tgt_n, pc_n;
    logic            jr_mis, new_valid, new_mis, pend_mis, pend_mis_n, red_n, mis_n;
    logic [1:0]      new_src, pend_src, pend_src_n, src_n;

    target_calc #(.XLEN(XLEN), .IDX_W(IDX_W), .OFF_W(OFF_W), .ALIGN(ALIGN)) u_calc (
        .j_pcp4  (j_pcp4_i),
        .j_index (j_index_i),
        .jr_addr (jr_addr_i),
        .br_pcp4 (br_pcp4_i),
        .br_off  (br_off_i),
        .j_tgt   (j_tgt),
        .jr_tgt  (jr_tgt),
        .jr_mis  (jr_mis),
        .br_tgt  (br_tgt)
    );

    assign new_valid = br_taken_i | jr_valid_i | j_valid_i;
    assign new_src   = br_taken_i ? SRC_BR : jr_valid_i ? SRC_JR : j_valid_i ? SRC_J : SRC_SEQ;
    assign new_tgt   = br_taken_i ? br_tgt : jr_valid_i ? jr_tgt : j_tgt;
    assign new_mis   = !br_taken_i && jr_valid_i && jr_mis;
    assign flush_o   = new_valid;
    assign pend_o    = (state == S_HOLD_P);

    always_comb begin
        state_n    = state;
        pc_n       = pc_o;
        red_n      = 1'b0;
        src_n      = SRC_SEQ;
        mis_n      = 1'b0;
        pend_tgt_n = pend_tgt;
        pend_src_n = pend_src;
        pend_mis_n = pend_mis;
        if (stall_i) begin
            // source encodings rise with priority, so a numeric compare ranks them
            if (new_valid && (state != S_HOLD_P || new_src > pend_src)) begin
                pend_tgt_n = new_tgt;
                pend_src_n = new_src;
                pend_mis_n = new_mis;
                state_n    = S_HOLD_P;
            end else if (state != S_HOLD_P) begin
                state_n = S_HOLD;
            end
        end else begin
            state_n = S_RUN;
            if (new_valid) begin
                pc_n  = new_tgt;
                red_n = 1'b1;
                src_n = new_src;
                mis_n = new_mis;
            end else if (state == S_HOLD_P) begin
                pc_n  = pend_tgt;
                red_n = 1'b1;
                src_n = pend_src;
                mis_n = pend_mis;
            end else begin
                pc_n = pc_o + STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_RUN;
            pc_o           <= RESET_PC;
            redirect_o     <= 1'b0;
            redirect_src_o <= SRC_SEQ;
            misalign_o     <= 1'b0;
            pend_tgt       <= '0;
            pend_src       <= SRC_SEQ;
            pend_mis       <= 1'b0;
        end else begin
            state          <= state_n;
            pc_o           <= pc_n;
            redirect_o     <= red_n;
            redirect_src_o <= src_n;
            misalign_o     <= mis_n;
            pend_tgt       <= pend_tgt_n;
            pend_src       <= pend_src_n;
            pend_mis       <= pend_mis_n;
        end
    end

`ifdef REDIRECT_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            j_cnt_o  <= '0;
            jr_cnt_o <= '0;
            br_cnt_o <= '0;
        end else if (red_n) begin
            if (src_n == SRC_J)  j_cnt_o  <= sat_inc16(j_cnt_o);
            if (src_n == SRC_JR) jr_cnt_o <= sat_inc16(jr_cnt_o);
            if (src_n == SRC_BR) br_cnt_o <= sat_inc16(br_cnt_o);
        end
    end
`endif
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed vectors with hand-computed expectations for pc_redirect_unit.
module tb_pc_redirect_unit;
    logic        clk = 1'b0;
    logic        reset, stall_i;
    logic        j_valid_i, jr_valid_i, br_taken_i;
    logic [31:0] j_pcp4_i, jr_addr_i, br_pcp4_i;
    logic [25:0] j_index_i;
    logic [15:0] br_off_i;
    logic [31:0] pc_o;
    logic        redirect_o, flush_o, misalign_o, pend_o;
    logic [1:0]  redirect_src_o;
`ifdef REDIRECT_STATS_EN
    logic [15:0] j_cnt_o, jr_cnt_o, br_cnt_o;
`endif
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_redirect_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall_i        (stall_i),
        .j_valid_i      (j_valid_i),
        .j_pcp4_i       (j_pcp4_i),
        .j_index_i      (j_index_i),
        .jr_valid_i     (jr_valid_i),
        .jr_addr_i      (jr_addr_i),
        .br_taken_i     (br_taken_i),
        .br_pcp4_i      (br_pcp4_i),
        .br_off_i       (br_off_i),
        .pc_o           (pc_o),
        .redirect_o     (redirect_o),
        .redirect_src_o (redirect_src_o),
        .flush_o        (flush_o),
        .misalign_o     (misalign_o),
`ifdef REDIRECT_STATS_EN
        .j_cnt_o        (j_cnt_o),
        .jr_cnt_o       (jr_cnt_o),
        .br_cnt_o       (br_cnt_o),
`endif
        .pend_o         (pend_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        j_valid_i  = 1'b0;
        jr_valid_i = 1'b0;
        br_taken_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall_i = 1'b0; idle();
        j_pcp4_i = '0; j_index_i = '0; jr_addr_i = '0; br_pcp4_i = '0; br_off_i = '0;
        step(); step();
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_red", {31'b0, redirect_o}, 32'h0);
        chk("rst_pend", {31'b0, pend_o}, 32'h0);
        chk("rst_src", {30'b0, redirect_src_o}, 32'h0);
        reset = 1'b0;
        step(); chk("seq4", pc_o, 32'h4);
        step(); chk("seq8", pc_o, 32'h8);
        step(); chk("seqC", pc_o, 32'hC);
        chk("seq_red", {31'b0, redirect_o}, 32'h0);
        chk("idle_flush", {31'b0, flush_o}, 32'h0);

        j_valid_i = 1'b1; j_pcp4_i = 32'h4000_0010; j_index_i = 26'h0000_100;
        #1 chk("j_flush", {31'b0, flush_o}, 32'h1);
        step(); idle();
        chk("j_pc", pc_o, 32'h4000_0400);
        chk("j_src", {30'b0, redirect_src_o}, 32'h1);
        chk("j_red", {31'b0, redirect_o}, 32'h1);
        step();
        chk("j_after_pc", pc_o, 32'h4000_0404);
        chk("j_after_red", {31'b0, redirect_o}, 32'h0);

        br_taken_i = 1'b1; br_pcp4_i = 32'h100; br_off_i = 16'hFFFC;
        j_valid_i = 1'b1; j_pcp4_i = 32'h0; j_index_i = 26'h50;
        #1 chk("br_flush", {31'b0, flush_o}, 32'h1);
        step(); idle();
        chk("br_pc", pc_o, 32'hF0);
        chk("br_src", {30'b0, redirect_src_o}, 32'h3);

        stall_i = 1'b1; jr_valid_i = 1'b1; jr_addr_i = 32'h2000;
        #1 chk("stall_flush", {31'b0, flush_o}, 32'h1);
        step(); idle();
        chk("st1_pc", pc_o, 32'hF0);
        chk("st1_pend", {31'b0, pend_o}, 32'h1);
        chk("st1_red", {31'b0, redirect_o}, 32'h0);
        br_taken_i = 1'b1; br_pcp4_i = 32'h300; br_off_i = 16'h0;
        step(); idle();
        chk("st2_pc", pc_o, 32'hF0);
        chk("st2_pend", {31'b0, pend_o}, 32'h1);
        j_valid_i = 1'b1; j_pcp4_i = 32'h0; j_index_i = 26'h50;
        step(); idle();
        chk("st3_pc", pc_o, 32'hF0);
        stall_i = 1'b0;
        step();
        chk("rel_pc", pc_o, 32'h300);
        chk("rel_src", {30'b0, redirect_src_o}, 32'h3);
        chk("rel_red", {31'b0, redirect_o}, 32'h1);
        chk("rel_pend", {31'b0, pend_o}, 32'h0);

        jr_valid_i = 1'b1; jr_addr_i = 32'h1003;
        step(); idle();
        chk("jr_pc", pc_o, 32'h1000);
        chk("jr_mis", {31'b0, misalign_o}, 32'h1);
        chk("jr_src", {30'b0, redirect_src_o}, 32'h2);
        step();
        chk("jr_mis_off", {31'b0, misalign_o}, 32'h0);
        chk("jr_seq", pc_o, 32'h1004);

        stall_i = 1'b1;
        step();
        chk("hold_pc", pc_o, 32'h1004);
        chk("hold_pend", {31'b0, pend_o}, 32'h0);
        j_valid_i = 1'b1; j_pcp4_i = 32'h0; j_index_i = 26'h40;
        step(); idle();
        chk("holdp_pend", {31'b0, pend_o}, 32'h1);
        stall_i = 1'b0; jr_valid_i = 1'b1; jr_addr_i = 32'h500;
        step(); idle();
        chk("outrank_pc", pc_o, 32'h500);
        chk("outrank_src", {30'b0, redirect_src_o}, 32'h2);
        chk("outrank_pend", {31'b0, pend_o}, 32'h0);

        stall_i = 1'b1; jr_valid_i = 1'b1; jr_addr_i = 32'h2000;
        step(); idle();
        chk("rstp_pend", {31'b0, pend_o}, 32'h1);
        reset = 1'b1;
        step();
        chk("rstp_pc", pc_o, 32'h0);
        chk("rstp_pend0", {31'b0, pend_o}, 32'h0);
        chk("rstp_red", {31'b0, redirect_o}, 32'h0);
        reset = 1'b0; stall_i = 1'b0;

        jr_valid_i = 1'b1; jr_addr_i = 32'hFFFF_FFFC;
        step(); idle();
        chk("wrap_top", pc_o, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc", pc_o, 32'h0);
        chk("wrap_red", {31'b0, redirect_o}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
